// File: rtl/spi_loader.sv
// SPI slave that turns 56-bit host frames into single-word AHB-Lite writes, then signals load-complete.
// Latency: 2 clk from the bit-56 sample to the address phase; backpressure: one-deep buffer, full drops and sets overflow.
module spi_loader #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_WRITE   = 8'hA5,
  parameter logic [7:0]  CMD_DONE    = 8'h5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] spi_haddr,
  output logic [31:0] spi_hwdata,
  output logic        spi_hwrite,
  output logic [1:0]  spi_htrans,
  output logic [2:0]  spi_hsize,
  output logic [2:0]  spi_hburst,
  output logic [3:0]  spi_hprot,
  output logic        spi_hmastlock,
  input  logic        spi_hready,
  input  logic        spi_hresp,
  input  logic [31:0] spi_hrdata,
  output logic        SPI_change,
  output logic        busy,
  output logic        overflow,
  output logic        bus_error
);

  localparam logic [5:0] LAST_BIT = 6'd55;
  localparam logic [5:0] FRAME_BITS = 6'd56;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;
  logic sclk_rise, sclk_fall, cs_fall;

  logic [5:0]  bit_cnt;
  logic [54:0] shift_sr;
  logic [55:0] frame_dat;
  logic        frame_vld;
  logic        wr_frame;
  logic        done_frame;

  logic        buf_vld;
  logic [15:0] buf_addr;
  logic [31:0] buf_dat;
  logic        buf_free;
  logic        done_req;

  logic [7:0]  status;
  logic [7:0]  tx_sr;

  logic        unused_hrdata;
  assign unused_hrdata = ^spi_hrdata;

  assign spi_hsize     = 3'b010;
  assign spi_hburst    = 3'b000;
  assign spi_hprot     = 4'b0011;
  assign spi_hmastlock = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;

  // The counter saturates at 56 so trailing bits in a long frame are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      shift_sr <= '0;
    end else if (cs_s) begin
      bit_cnt <= '0;
    end else if (sclk_rise && (bit_cnt < FRAME_BITS)) begin
      bit_cnt  <= bit_cnt + 6'd1;
      shift_sr <= {shift_sr[53:0], mosi_s};
    end
  end

  assign frame_dat  = {shift_sr, mosi_s};
  assign frame_vld  = sclk_rise && !cs_s && (bit_cnt == LAST_BIT) && (state != S_DONE);
  assign wr_frame   = frame_vld && (frame_dat[55:48] == CMD_WRITE);
  assign done_frame = frame_vld && (frame_dat[55:48] == CMD_DONE);
  assign buf_free   = (state == S_DATA) && spi_hready;

  // A frame landing on the same cycle the buffer drains still counts as full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_vld   <= 1'b0;
      buf_addr  <= '0;
      buf_dat   <= '0;
      overflow  <= 1'b0;
      bus_error <= 1'b0;
      done_req  <= 1'b0;
    end else begin
      if (buf_free) begin
        buf_vld <= 1'b0;
      end
      if (wr_frame && !buf_vld) begin
        buf_vld  <= 1'b1;
        buf_addr <= frame_dat[47:32];
        buf_dat  <= frame_dat[31:0];
      end
      if (wr_frame && buf_vld) begin
        overflow <= 1'b1;
      end
      if (buf_free && spi_hresp) begin
        bus_error <= 1'b1;
      end
      if (done_frame) begin
        done_req <= 1'b1;
      end
    end
  end

  assign busy   = buf_vld;
  assign status = {5'b0, bus_error, overflow, buf_vld};

  // Bit 7 goes out at chip-select fall so it is valid before the first rising sclk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miso  <= 1'b0;
      tx_sr <= '0;
    end else if (cs_s) begin
      miso <= 1'b0;
    end else if (cs_fall) begin
      miso  <= status[7];
      tx_sr <= {status[6:0], 1'b0};
    end else if (sclk_fall) begin
      if (bit_cnt < 6'd8) begin
        miso  <= tx_sr[7];
        tx_sr <= {tx_sr[6:0], 1'b0};
      end else begin
        miso <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending writes win over done_req so SPI_change never overtakes a write.
  always_comb begin
    state_nxt  = state;
    spi_htrans = HTRANS_IDLE;
    spi_haddr  = '0;
    spi_hwdata = '0;
    spi_hwrite = 1'b0;
    SPI_change = 1'b0;
    case (state)
      S_IDLE: begin
        if (buf_vld) begin
          state_nxt = S_ADDR;
        end else if (done_req) begin
          state_nxt  = S_DONE;
          SPI_change = 1'b1;
        end
      end
      S_ADDR: begin
        spi_htrans = HTRANS_NONSEQ;
        spi_hwrite = 1'b1;
        spi_haddr  = {16'h0000, buf_addr};
        if (spi_hready) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        spi_hwdata = buf_dat;
        if (spi_hready) begin
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/spi_loader.md
Name: spi_loader

Overview:
- SPI slave plus AHB-Lite master. It receives program and data images from an external host and writes them into instruction RAM, data RAM and the register space.
- It sits directly upstream of the router and drives the router's spi_h* AHB port.
- When the host signals load-complete, it pulses SPI_change so the router hands the memories over to the RISC-V core.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the SPI input synchronizers (minimum 2).
- CMD_WRITE, 8'hA5, frame command byte meaning "write one word".
- CMD_DONE, 8'h5A, frame command byte meaning "load complete".

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock from host, asynchronous, mode 0
- cs_n  in  1  SPI chip select, active low, asynchronous
- mosi  in  1  SPI data in, MSB first
- miso  out  1  SPI data out (status byte)
- spi_haddr  out  32  AHB address
- spi_hwdata  out  32  AHB write data
- spi_hwrite  out  1  AHB write flag
- spi_htrans  out  2  AHB transfer type
- spi_hsize  out  3  AHB size
- spi_hburst  out  3  AHB burst type
- spi_hprot  out  4  AHB protection
- spi_hmastlock  out  1  AHB lock
- spi_hready  in  1  AHB ready from router
- spi_hresp  in  1  AHB response from router (1 = ERROR)
- spi_hrdata  in  32  AHB read data; unused, ignored
- SPI_change  out  1  one-clk pulse: load complete, router leaves SPI mode
- busy  out  1  AHB transfer pending or in flight
- overflow  out  1  sticky: a word was dropped because the buffer was full
- bus_error  out  1  sticky: an AHB ERROR response was received

Behaviour:
- Reset (reset=0, async) values:
  - spi_htrans=2'b00, spi_haddr=0, spi_hwdata=0, spi_hwrite=0.
  - spi_hsize=3'b010, spi_hburst=3'b000, spi_hprot=4'b0011, spi_hmastlock=0.
  - SPI_change=0, miso=0, busy=0, overflow=0, bus_error=0.
  - Bit counter and FSMs cleared.
- Input sync: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Rising and falling edges of sclk are detected in the clk domain. sclk period ≥ 8 clk cycles is required.
- Frame format: cs_n low, then 56 bits sampled on sclk rising edges: cmd[7:0], addr[15:0], data[31:0], MSB first.
- A 6-bit bit counter clears whenever cs_n is high.
- cs_n rising before bit 56: the frame is discarded, with no side effects.
- Bits beyond 56 within the same cs_n-low window are ignored.
- miso:
  - Shifts out the status byte {5'b0, bus_error, overflow, busy} during bits 0-7, updated on sclk falling edges.
  - The status byte is captured at the cs_n falling edge.
  - miso is 0 for all other bits and while cs_n is high.
- Frame completion (bit 56 sampled):
  - CMD_WRITE with buffer empty: load {addr, data} into a one-deep buffer; busy=1 on the next clk.
  - CMD_WRITE with buffer full: drop the word; overflow<=1 (sticky until reset).
  - CMD_DONE: set done_req.
  - Any other command: ignored.
  - Any frame while in DONE: ignored.
- AHB FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE:
    - Buffer full → ADDR. Drive spi_htrans=2'b10, spi_hwrite=1, spi_haddr={16'h0000, addr}.
    - Else done_req and buffer empty → DONE. SPI_change=1 for exactly one clk.
  - ADDR: when spi_hready=1 → DATA. Drive spi_hwdata=data, spi_htrans=2'b00, spi_hwrite=0. If spi_hready=0, hold all address-phase outputs.
  - DATA:
    - Hold spi_hwdata until spi_hready=1.
    - If spi_hresp=1 on that cycle, set bus_error<=1.
    - Either way, free the buffer, busy<=0, → IDLE.
  - DONE: terminal. SPI_change stays 0 after the pulse; leave only by reset.
- Minimum write latency from bit-56 sample to address phase: 2 clk (buffer load, then ADDR).
- done_req is honoured only after any pending buffered write completes, so writes and SPI_change stay ordered.
- spi_hsize, spi_hburst, spi_hprot and spi_hmastlock are constant at their reset values.
- Reset mid-frame or mid-transfer: everything returns to reset values immediately. The partial frame is lost and spi_htrans=2'b00.

Test Plan:
- Write frame cmd=A5, addr=0x0004, data=0xDEADBEEF, hready=1 → one NONSEQ with haddr=0x00000004, hwrite=1, next cycle hwdata=0xDEADBEEF; busy returns to 0.
- Write frame to addr=0x8002 with spi_hready held 0 for 5 clks in ADDR → address-phase outputs stable for 5 clks; transfer completes after hready=1.
- Write frame to 0x4010, then a second write frame while hready=0 holds the first → second word dropped, overflow=1; first word written correctly.
- cs_n raised after 30 bits, then a full frame A5/0x0000/0x12345678 → only the full frame produces an AHB write.
- Write frame then cmd=5A → SPI_change pulses once, after the write's data phase; a later A5 frame produces no AHB activity.
- hresp=1 during data phase → bus_error=1; the next status byte on miso reads 8'b0000_0100; reset clears it to 0.
